led_status_ctrl: RTL and testbench
==================================

Name: led_status_ctrl

Overview:
- Parametrised front-panel LED driver for N_LED bi-colour (red/green) indicators.
- Takes a per-channel 2-bit mode word and resynchronises it into the clk domain through SYNC_STAGES flops.
- Generates solid, blink and red/green alternate patterns from a shared prescaler, plus a self-timed lamp-test sequence.
- Sits between the status/register logic and the LED pins.

Parameters:
- N_LED, 8, number of bi-colour LED channels (1..32).
- SYNC_STAGES, 2, resynchroniser depth on mode_in and lamp_test (>=1).
- BLINK_HALF, 25000000, clk cycles per blink half-period (>=2).
- LAMP_CYCLES, 50000000, clk cycles per lamp-test step (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock, reset is asynchronous and active-low.
- mode_in  in  2*N_LED  channel i mode at bits [2i+1:2i]. Encoding: 00 RED, 01 GREEN, 10 BLINK, 11 ALT. May be asynchronous to clk.
- lamp_test  in  1  lamp-test request; rising edge starts a test. May be asynchronous.
- led_r  out  N_LED  red drive, 1 = on.
- led_g  out  N_LED  green drive, 1 = on.
- test_busy  out  1  high while a lamp test runs.

Behaviour:
- Reset (rst=0) takes effect immediately, with no clock needed:
  - led_r = all 1, led_g = all 0, test_busy = 0.
  - All sync flops cleared to 0.
  - Prescaler count = 0, blink phase = 0, FSM in IDLE, step counter = 0.
- Reset mid-test: all state returns to these reset values at once; no test resumes after reset is released.
- Sync: mode_in and lamp_test each pass through SYNC_STAGES flops, producing mode_s and lt_s. The first clock edges after reset therefore see mode_s = 0 (RED).
- Edge detect: lt_s is registered once more; start = lt_s & ~lt_s_d.
- Prescaler:
  - Counts 0..BLINK_HALF-1, then wraps to 0.
  - Blink phase toggles on the wrap cycle, so the pattern period is 2*BLINK_HALF cycles at 50% duty.
  - Free-running, independent of mode and FSM.
- Channel decode in IDLE:
  - RED: r=1, g=0.
  - GREEN: r=0, g=1.
  - BLINK: r=0, g=phase.
  - ALT: r=~phase, g=phase.
- Lamp-test FSM has states IDLE, ALL_RED, ALL_GREEN, ALL_ON.
  - IDLE -> ALL_RED on start; the step counter is cleared on this transition.
  - Each test state holds for exactly LAMP_CYCLES cycles, counting 0..LAMP_CYCLES-1, then advances ALL_RED -> ALL_GREEN -> ALL_ON -> IDLE, clearing the counter.
  - start is ignored outside IDLE: no restart, no queuing.
  - A lamp_test held high after the test ends does not retrigger; a new rising edge is needed.
- Forced outputs during the test:
  - ALL_RED: r = all 1, g = all 0.
  - ALL_GREEN: r = all 0, g = all 1.
  - ALL_ON: r = all 1, g = all 1.
- Outputs: led_r, led_g and test_busy are registered from the current state, mode_s and phase, so they lag state by 1 cycle.
  - mode_in change to output: SYNC_STAGES+1 edges.
  - lamp_test rise to test_busy=1: SYNC_STAGES+3 edges. test_busy stays high for 3*LAMP_CYCLES cycles.
- Mode changes during a test are tracked in mode_s and appear on the first output cycle after the FSM returns to IDLE.
- Mode values are never lost or latched beyond the sync chain: the output always follows the newest synchronised value.
- The decode has no illegal mode encodings.

Decomposition:
- Package led_pkg holds:
  - mode localparams MODE_RED=2'b00, MODE_GREEN=2'b01, MODE_BLINK=2'b10, MODE_ALT=2'b11;
  - FSM state encoding (2-bit: IDLE=0, ALL_RED=1, ALL_GREEN=2, ALL_ON=3).
- Sub-module sync_bus #(WIDTH, STAGES): generic multi-flop resynchroniser with async active-low clear. It is instantiated twice (mode_in, lamp_test).
- The prescaler, FSM and per-channel decode (generate loop) stay in the top.

Test Plan:
Common parameters: N_LED=4, SYNC_STAGES=2, BLINK_HALF=4, LAMP_CYCLES=6.
1. Reset: hold rst=0 with mode_in=8'hFF -> led_r=4'hF, led_g=4'h0, test_busy=0, with no clk edge required.
2. Sync latency: after reset, drive mode_in=8'h55 (all GREEN) before edge k -> led_g=4'hF and led_r=4'h0 first seen after edge k+2; unchanged at edge k+1.
3. Blink/alt: mode_in=8'b11_10_01_00 -> ch0 r=1,g=0; ch1 g=1; ch2 g toggles every 4 cycles (period 8); ch3 r/g complementary, never both 1 or both 0.
4. Lamp test: pulse lamp_test for 3 cycles -> test_busy high for exactly 18 cycles. Sequence is 6 cycles r=F,g=0, then 6 cycles r=0,g=F, then 6 cycles r=F,g=F, then mode-driven outputs resume. A second pulse at cycle 8 of the test changes nothing.
5. Level hold: lamp_test held high for 40 cycles -> exactly one 18-cycle test. Low for 4 cycles then high again -> second test starts.
6. Reset mid-test: assert rst=0 during ALL_GREEN -> outputs immediately r=F, g=0, busy=0. After release with lamp_test still high, no test starts until a new rising edge.

Source files
------------

// File: rtl/led_pkg.sv
// Shared encodings for the front-panel LED driver: channel modes, lamp-test states
// and the per-channel mode decode.
package led_pkg;

   localparam logic [1:0] MODE_RED   = 2'b00;
   localparam logic [1:0] MODE_GREEN = 2'b01;
   localparam logic [1:0] MODE_BLINK = 2'b10;
   localparam logic [1:0] MODE_ALT   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ALL_RED   = 2'd1,
      ST_ALL_GREEN = 2'd2,
      ST_ALL_ON    = 2'd3
   } lt_state_e;

   // Returns {red, green} for one channel.
   function automatic logic [1:0] decode_mode(input logic [1:0] mode, input logic phase);
      case (mode)
         MODE_RED:   return 2'b10;
         MODE_GREEN: return 2'b01;
         MODE_BLINK: return {1'b0, phase};
         default:    return {~phase, phase};
      endcase
   endfunction

endpackage

// File: rtl/sync_bus.sv
// Multi-flop resynchroniser for a bus of level signals, async active-low clear.
// Latency STAGES clk edges; no flow control.
module sync_bus #(
   parameter int unsigned WIDTH  = 1,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sync_q [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/led_status_ctrl.sv
// Bi-colour LED driver: solid/blink/alternate patterns per channel plus a self-timed lamp test.
// Mode to pin SYNC_STAGES+1 edges, lamp_test rise to test_busy SYNC_STAGES+3 edges; no backpressure.
module led_status_ctrl
   import led_pkg::*;
#(
   parameter int unsigned N_LED       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned BLINK_HALF  = 25000000,
   parameter int unsigned LAMP_CYCLES = 50000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2*N_LED-1:0] mode_in,
   input  logic               lamp_test,
   output logic [N_LED-1:0]   led_r,
   output logic [N_LED-1:0]   led_g,
   output logic               test_busy
);

   localparam int unsigned PW = $clog2(BLINK_HALF);
   localparam int unsigned SW = $clog2(LAMP_CYCLES);
   localparam int unsigned FW = $clog2(SYNC_STAGES + 1);

   logic [2*N_LED-1:0] mode_s;
   logic               lt_s;
   logic [FW-1:0]      flush_q;
   logic               lt_ready;
   logic               lt_dly_q;
   logic               start_q;
   logic [PW-1:0]      presc_q, presc_d;
   logic               phase_q, phase_d;
   lt_state_e          state_q;
   logic [SW-1:0]      step_q;
   logic               step_last;
   logic [N_LED-1:0]   dec_r, dec_g;
   logic [N_LED-1:0]   led_r_q, led_g_q;
   logic               busy_q;

   sync_bus #(.WIDTH(2*N_LED), .STAGES(SYNC_STAGES)) u_sync_mode (
      .clk   (clk),
      .rst_n (rst),
      .d_i   (mode_in),
      .q_o   (mode_s)
   );

   sync_bus #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_lt (
      .clk   (clk),
      .rst_n (rst),
      .d_i   (lamp_test),
      .q_o   (lt_s)
   );

   // The cleared sync chain looks like a low level; edges are only armed once it has flushed,
   // so a lamp_test held high across reset never fakes a rising edge.
   assign lt_ready = (flush_q == FW'(SYNC_STAGES));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flush_q  <= '0;
         lt_dly_q <= 1'b1;
         start_q  <= 1'b0;
      end else begin
         if (!lt_ready) flush_q <= flush_q + 1'b1;
         lt_dly_q <= lt_ready ? lt_s : 1'b1;
         start_q  <= lt_ready & lt_s & ~lt_dly_q;
      end
   end

   always_comb begin
      presc_d = presc_q + 1'b1;
      phase_d = phase_q;
      if (presc_q == PW'(BLINK_HALF - 1)) begin
         presc_d = '0;
         phase_d = ~phase_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_q <= '0;
         phase_q <= 1'b0;
      end else begin
         presc_q <= presc_d;
         phase_q <= phase_d;
      end
   end

   for (genvar i = 0; i < N_LED; i++) begin : g_ch
      assign {dec_r[i], dec_g[i]} = decode_mode(mode_s[2*i +: 2], phase_q);
   end

   assign step_last = (step_q == SW'(LAMP_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
         led_r_q <= '1;
         led_g_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         if (state_q == ST_IDLE) begin
            if (start_q) begin
               state_q <= ST_ALL_RED;
               step_q  <= '0;
            end
         end else if (step_last) begin
            step_q  <= '0;
            state_q <= (state_q == ST_ALL_RED)   ? ST_ALL_GREEN :
                       (state_q == ST_ALL_GREEN) ? ST_ALL_ON    : ST_IDLE;
         end else begin
            step_q <= step_q + 1'b1;
         end

         case (state_q)
            ST_ALL_RED: begin
               led_r_q <= '1;
               led_g_q <= '0;
               busy_q  <= 1'b1;
            end
            ST_ALL_GREEN: begin
               led_r_q <= '0;
               led_g_q <= '1;
               busy_q  <= 1'b1;
            end
            ST_ALL_ON: begin
               led_r_q <= '1;
               led_g_q <= '1;
               busy_q  <= 1'b1;
            end
            default: begin
               led_r_q <= dec_r;
               led_g_q <= dec_g;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign led_r     = led_r_q;
   assign led_g     = led_g_q;
   assign test_busy = busy_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed and random stimulus for led_status_ctrl against a timeline model of the LED outputs.
module tb_led_status_ctrl;

   localparam int N  = 4;
   localparam int SS = 2;
   localparam int BH = 4;
   localparam int LC = 6;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [2*N-1:0] mode_in = '0;
   logic           lamp_test = 1'b0;
   logic [N-1:0]   led_r, led_g;
   logic           test_busy;

   int checks = 0;
   int errors = 0;

   // Model state: input samples per edge since reset release, and the accepted test start.
   logic [7:0] mh [0:4095];
   logic       lh [0:4095];
   int         n;
   bit         has_test;
   int         t0;
   int         busy_cnt;
   bit         found;

   led_status_ctrl #(
      .N_LED       (N),
      .SYNC_STAGES (SS),
      .BLINK_HALF  (BH),
      .LAMP_CYCLES (LC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mode_in   (mode_in),
      .lamp_test (lamp_test),
      .led_r     (led_r),
      .led_g     (led_g),
      .test_busy (test_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // {r, g} for one channel straight from the mode table.
   function automatic logic [1:0] ref_ch(input logic [1:0] m, input bit ph);
      case (m)
         2'b00:   return 2'b10;
         2'b01:   return 2'b01;
         2'b10:   return {1'b0, ph};
         default: return {~ph, ph};
      endcase
   endfunction

   task automatic model_reset();
      n        = 0;
      has_test = 1'b0;
      t0       = 0;
      busy_cnt = 0;
   endtask

   // One clock: record the sampled inputs, advance the timeline, compare all outputs.
   task automatic step();
      int          e;
      int          k;
      bit          ph;
      logic [7:0]  m;
      logic [N-1:0] er, eg;
      logic        eb;
      logic [1:0]  rg;
      mh[n+1] = mode_in;
      lh[n+1] = lamp_test;
      @(posedge clk);
      n++;
      // A rising sample reaches the FSM three edges later; it only counts if no test is running then.
      if (n >= 2 && lh[n] && !lh[n-1] && (!has_test || n + 2 >= t0 + 3*LC)) begin
         has_test = 1'b1;
         t0       = n + 3;
      end
      #1;
      e  = n - 1;
      ph = ((e / BH) % 2) != 0;
      m  = (n >= 3) ? mh[n-2] : 8'h00;
      if (has_test && e >= t0 && e < t0 + 3*LC) begin
         k  = (e - t0) / LC;
         er = (k == 1) ? 4'h0 : 4'hF;
         eg = (k == 0) ? 4'h0 : 4'hF;
         eb = 1'b1;
      end else begin
         for (int i = 0; i < N; i++) begin
            rg    = ref_ch(m[2*i +: 2], ph);
            er[i] = rg[1];
            eg[i] = rg[0];
         end
         eb = 1'b0;
      end
      if (test_busy) busy_cnt++;
      chk($sformatf("cyc%0d_rgb", n), {7'd0, led_r, led_g, test_busy}, {7'd0, er, eg, eb});
   endtask

   initial begin
      // 1. Asynchronous reset with no clock edge.
      mode_in = 8'hFF;
      #1 rst = 1'b0;
      #1;
      chk("reset_r", 16'(led_r), 16'hF);
      chk("reset_g", 16'(led_g), 16'h0);
      chk("reset_busy", 16'(test_busy), 16'h0);
      repeat (2) @(posedge clk);
      #1 chk("reset_hold_r", 16'(led_r), 16'hF);

      // 2. Sync latency.
      mode_in = 8'h00;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      step();
      step();
      mode_in = 8'h55;
      step();
      chk("sync_k_g", 16'(led_g), 16'h0);
      step();
      chk("sync_k1_g", 16'(led_g), 16'h0);
      chk("sync_k1_r", 16'(led_r), 16'hF);
      step();
      chk("sync_k2_g", 16'(led_g), 16'hF);
      chk("sync_k2_r", 16'(led_r), 16'h0);

      // 3. Mixed modes: red, green, blink, alternate.
      mode_in = 8'b11_10_01_00;
      for (int i = 0; i < 40; i++) begin
         step();
         if (i >= 3) chk("alt_excl", 16'(led_r[3] ^ led_g[3]), 16'h1);
      end

      // 4. Pulsed lamp test with an ignored second pulse.
      busy_cnt  = 0;
      lamp_test = 1'b1;
      repeat (3) step();
      lamp_test = 1'b0;
      repeat (10) step();
      lamp_test = 1'b1;
      repeat (3) step();
      lamp_test = 1'b0;
      repeat (30) step();
      chk("pulse_busy_len", 16'(busy_cnt), 16'd18);

      // 5. Level hold, then a fresh edge.
      busy_cnt  = 0;
      lamp_test = 1'b1;
      repeat (40) step();
      chk("level_one_test", 16'(busy_cnt), 16'd18);
      lamp_test = 1'b0;
      repeat (4) step();
      lamp_test = 1'b1;
      repeat (30) step();
      chk("level_second_test", 16'(busy_cnt), 16'd36);
      lamp_test = 1'b0;
      repeat (4) step();

      // Random modes and lamp-test activity.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(7) == 0) mode_in = 8'($urandom);
         if ($urandom_range(19) == 0) lamp_test = ~lamp_test;
         step();
      end

      // 6. Reset during ALL_GREEN with lamp_test left high.
      lamp_test = 1'b0;
      repeat (30) step();
      lamp_test = 1'b1;
      found     = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (test_busy && led_g == 4'hF && led_r == 4'h0) begin
            found = 1'b1;
            break;
         end
      end
      chk("reach_all_green", 16'(found), 16'h1);
      #2 rst = 1'b0;
      #1;
      chk("midrst_r", 16'(led_r), 16'hF);
      chk("midrst_g", 16'(led_g), 16'h0);
      chk("midrst_busy", 16'(test_busy), 16'h0);
      repeat (2) @(posedge clk);
      #1 chk("midrst_hold_busy", 16'(test_busy), 16'h0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      repeat (30) step();
      chk("no_restart_after_rst", 16'(busy_cnt), 16'd0);
      lamp_test = 1'b0;
      repeat (3) step();
      lamp_test = 1'b1;
      repeat (25) step();
      chk("new_edge_after_rst", 16'(busy_cnt), 16'd18);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
